// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding, coin-select
// codes, denomination values and a select-to-value helper.
package change_dispenser_pkg;

  localparam int AMT_W     = 10;  // width of amounts in sen
  localparam int NUM_COINS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  // Coin-select codes. A lower code means a larger coin, which the priority
  // pick in coin_picker relies on.
  localparam logic [1:0] COIN_50 = 2'd0;
  localparam logic [1:0] COIN_20 = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_5  = 2'd3;

  localparam logic [AMT_W-1:0] VAL_50 = 10'd50;
  localparam logic [AMT_W-1:0] VAL_20 = 10'd20;
  localparam logic [AMT_W-1:0] VAL_10 = 10'd10;
  localparam logic [AMT_W-1:0] VAL_5  = 10'd5;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
    logic [AMT_W-1:0] v;
    unique case (sel)
      COIN_50: v = VAL_50;
      COIN_20: v = VAL_20;
      COIN_10: v = VAL_10;
      default: v = VAL_5;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the change dispenser, its upstream controller and the coin
// hopper.
//   upstream -> dispenser : start, amount, maintenance, restock_we,
//                           restock_sel, restock_cnt
//   dispenser -> hopper   : eject_req, eject_sel
//   hopper -> dispenser   : eject_ack (four-phase acknowledge)
//   dispenser -> upstream : busy, done, short, fault, remaining, stock_empty
// Modport master is the upstream/hopper side, slave is the dispenser.
interface change_dispenser_if #(
  parameter int STOCK_W = 8
);
  import change_dispenser_pkg::*;

  logic               start;
  logic [AMT_W-1:0]   amount;
  logic               maintenance;
  logic               restock_we;
  logic [1:0]         restock_sel;
  logic [STOCK_W-1:0] restock_cnt;
  logic               eject_req;
  logic [1:0]         eject_sel;
  logic               eject_ack;
  logic               busy;
  logic               done;
  logic               short;
  logic               fault;
  logic [AMT_W-1:0]   remaining;
  logic [3:0]         stock_empty;

  modport master (
    output start, amount, maintenance, restock_we, restock_sel, restock_cnt,
    output eject_ack,
    input  eject_req, eject_sel, busy, done, short, fault, remaining, stock_empty
  );

  modport slave (
    input  start, amount, maintenance, restock_we, restock_sel, restock_cnt,
    input  eject_ack,
    output eject_req, eject_sel, busy, done, short, fault, remaining, stock_empty
  );

endinterface

// File: rtl/change_dispenser_coin_picker.sv
// Combinational greedy coin selection: returns the largest denomination whose
// value fits in the remaining amount and whose stock is not empty.
//   remaining_i   : amount still owed, in sen
//   stock_empty_i : bit i set when coin i has no stock
//   sel_o         : chosen coin-select code (valid when found_o)
//   found_o       : a candidate coin exists
module coin_picker
  import change_dispenser_pkg::*;
(
  input  logic [AMT_W-1:0]     remaining_i,
  input  logic [NUM_COINS-1:0] stock_empty_i,
  output logic [1:0]           sel_o,
  output logic                 found_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sel_o   = '0;
    found_o = 1'b0;
    // Walk smallest to largest so the largest eligible coin is written last
    // and wins.
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (!stock_empty_i[i] && (coin_value(2'(i)) <= remaining_i)) begin
        sel_o   = 2'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount through a coin hopper using a greedy
// loop over 50/20/10/5 sen coins with per-coin stock counters, a four-phase
// eject_req/eject_ack handshake and a hopper timeout fault.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-low
//   bus   : change_dispenser_if slave modport (control, restock, hopper
//           handshake and status)
// Parameters: TIMEOUT = cycles eject_req may wait for eject_ack,
//             STOCK_W = width of each coin stock counter.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int STOCK_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [1:0]         sel_q, sel_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [STOCK_W-1:0] stock_q [NUM_COINS];
  logic [STOCK_W-1:0] stock_d [NUM_COINS];

  logic [NUM_COINS-1:0] stock_empty;
  logic [1:0]           pick_sel;
  logic                 pick_found;
  logic                 restock_ok;

  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_COINS; i++) begin
      stock_empty[i] = (stock_q[i] == '0);
    end
  end

  coin_picker u_picker (
    .remaining_i   (remaining_q),
    .stock_empty_i (stock_empty),
    .sel_o         (pick_sel),
    .found_o       (pick_found)
  );

  // Restocking is only honoured while idle or faulted; an accepted start in
  // the same cycle takes precedence and the restock is dropped.
  assign restock_ok = bus.maintenance && bus.restock_we &&
                      (((state_q == ST_IDLE) && !bus.start) || (state_q == ST_FAULT));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sel_d       = sel_q;
    tmo_d       = tmo_q;
    stock_d     = stock_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.amount;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if ((remaining_q == '0) || !pick_found) begin
          state_d = ST_FINISH;
        end else begin
          sel_d   = pick_sel;
          tmo_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.eject_ack) begin
          // Selection guaranteed value <= remaining and stock > 0, so
          // neither subtraction can wrap.
          remaining_d    = remaining_q - coin_value(sel_q);
          stock_d[sel_q] = stock_q[sel_q] - 1'b1;
          state_d        = ST_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!bus.eject_ack) state_d = ST_SELECT;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (bus.maintenance && !bus.restock_we) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restock_ok) begin
      stock_d[bus.restock_sel] = sat_add(stock_q[bus.restock_sel], bus.restock_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      sel_q       <= '0;
      tmo_q       <= '0;
      // NOTE: the stock counters are a small register array that must read as
      // empty after reset, so they are cleared here rather than left unreset
      // like a RAM would be.
      for (int i = 0; i < NUM_COINS; i++) begin
        stock_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
      for (int i = 0; i < NUM_COINS; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset drops eject_req and busy without waiting for a clock edge.
  assign bus.eject_req   = (state_q == ST_REQ);
  assign bus.eject_sel   = sel_q;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign bus.done        = (state_q == ST_FINISH);
  assign bus.short       = (state_q == ST_FINISH) && (remaining_q != '0);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.remaining   = remaining_q;
  assign bus.stock_empty = stock_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: a hand-derived vector table, directed
// multi-cycle sequences (timeout, saturation, busy start, reset in REQ) and
// randomized payouts compared against an arithmetic greedy model.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int TIMEOUT = 255;
  localparam int STOCK_W = 8;
  localparam int STOCK_MAX = (1 << STOCK_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_dispenser_if #(.STOCK_W(STOCK_W)) bus ();

  change_dispenser #(.TIMEOUT(TIMEOUT), .STOCK_W(STOCK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- hopper model and coin logger ----------------
  bit hop_en    = 1'b1;
  int hop_max   = 0;
  int hop_delay = 0;
  int hop_wait  = 0;

  always @(negedge clk) begin
    if (!hop_en || !rst) begin
      bus.eject_ack = 1'b0;
      hop_wait = 0;
    end else if (bus.eject_req && !bus.eject_ack) begin
      if (hop_wait >= hop_delay) begin
        bus.eject_ack = 1'b1;
        hop_wait  = 0;
        hop_delay = $urandom_range(0, hop_max);
      end else begin
        hop_wait++;
      end
    end else if (!bus.eject_req) begin
      bus.eject_ack = 1'b0;
    end
  end

  int coin_log[$];
  bit req_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.eject_req && !req_prev) coin_log.push_back(int'(bus.eject_sel));
    req_prev = bus.eject_req;
  end

  // ---------------- reference model ----------------
  int den[4] = '{50, 20, 10, 5};
  int mstock[4];
  int exp_q[$];

  // Greedy by denomination: take as many of each coin as fit, largest first.
  task automatic model_pay(input int amt, output int rem);
    exp_q.delete();
    rem = amt;
    for (int d = 0; d < 4; d++) begin
      int n;
      n = rem / den[d];
      if (n > mstock[d]) n = mstock[d];
      repeat (n) exp_q.push_back(d);
      mstock[d] -= n;
      rem -= n * den[d];
    end
  endtask

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mstock[i] == 0);
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.amount = '0; bus.maintenance = 1'b0;
    bus.restock_we = 1'b0; bus.restock_sel = '0; bus.restock_cnt = '0;
    for (int i = 0; i < 4; i++) mstock[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic restock(input int sel, input int cnt);
    bus.maintenance = 1'b1; bus.restock_we = 1'b1;
    bus.restock_sel = 2'(sel); bus.restock_cnt = STOCK_W'(cnt);
    @(negedge clk);
    bus.maintenance = 1'b0; bus.restock_we = 1'b0;
    mstock[sel] = (mstock[sel] + cnt > STOCK_MAX) ? STOCK_MAX : mstock[sel] + cnt;
  endtask

  // Pulse start, optionally inject a second start while busy, and wait
  // (bounded) for done. lat counts falling edges from start to done.
  task automatic run_payout(input int amt, input int inj_at, input bit with_rs,
                            output int rem, output int shrt, output int lat);
    bit seen;
    coin_log.delete();
    bus.amount = AMT_W'(amt);
    bus.start  = 1'b1;
    if (with_rs) begin
      bus.maintenance = 1'b1; bus.restock_we = 1'b1;
      bus.restock_sel = 2'd3; bus.restock_cnt = STOCK_W'(1);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.maintenance = 1'b0; bus.restock_we = 1'b0;
    seen = 1'b0; lat = 0; rem = -1; shrt = -1;
    for (int cyc = 1; cyc <= 4000 && !seen; cyc++) begin
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1; lat = cyc;
        rem = int'(bus.remaining); shrt = int'(bus.short);
      end else begin
        if (cyc == inj_at) begin
          bus.start = 1'b1; bus.amount = AMT_W'(5);
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
    end
  endtask

  task automatic pay_vs_model(input string tag, input int amt, input int inj_at);
    int erem, rem, shrt, lat;
    model_pay(amt, erem);
    run_payout(amt, inj_at, 1'b0, rem, shrt, lat);
    check({tag, "_ncoins"}, coin_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < coin_log.size(); k++)
      check({tag, "_coin"}, coin_log[k], exp_q[k]);
    check({tag, "_rem"}, rem, erem);
    check({tag, "_short"}, shrt, (erem != 0));
    check({tag, "_empty"}, bus.stock_empty, model_empty());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         stk[4];
    int         amount;
    int         n;
    int         seq[5];
    int         rem;
    int         shrt;
    logic [3:0] empty;
    int         lat;   // 0 = not checked
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rem, shrt, lat, cnt;

    vecs[0] = '{stk:'{10,10,10,10}, amount:85,  n:4, seq:'{0,1,2,3,0}, rem:0,  shrt:0, empty:4'b0000, lat:0};
    vecs[1] = '{stk:'{0,1,0,1},     amount:45,  n:2, seq:'{1,3,0,0,0}, rem:20, shrt:1, empty:4'b1111, lat:0};
    vecs[2] = '{stk:'{10,10,10,10}, amount:7,   n:1, seq:'{3,0,0,0,0}, rem:2,  shrt:1, empty:4'b0000, lat:5};
    vecs[3] = '{stk:'{10,10,10,10}, amount:0,   n:0, seq:'{0,0,0,0,0}, rem:0,  shrt:0, empty:4'b0000, lat:2};
    vecs[4] = '{stk:'{2,0,3,0},     amount:130, n:5, seq:'{0,0,2,2,2}, rem:0,  shrt:0, empty:4'b1111, lat:0};
    vecs[5] = '{stk:'{0,0,0,0},     amount:50,  n:0, seq:'{0,0,0,0,0}, rem:50, shrt:1, empty:4'b1111, lat:0};
    vecs[6] = '{stk:'{1,5,0,0},     amount:60,  n:1, seq:'{0,0,0,0,0}, rem:10, shrt:1, empty:4'b1101, lat:0};

    bus.eject_ack = 1'b0;
    do_reset();

    // Reset state
    check("rst_eject_req", bus.eject_req, 0);
    check("rst_eject_sel", bus.eject_sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_short", bus.short, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_remaining", bus.remaining, 0);
    check("rst_stock_empty", bus.stock_empty, 4'b1111);

    // Table-driven payouts
    hop_en = 1'b1; hop_max = 0; hop_delay = 0;
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int s = 0; s < 4; s++) if (vecs[v].stk[s] > 0) restock(s, vecs[v].stk[s]);
      run_payout(vecs[v].amount, 0, 1'b0, rem, shrt, lat);
      check("tbl_ncoins", coin_log.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < coin_log.size(); k++)
        check("tbl_coin", coin_log[k], vecs[v].seq[k]);
      check("tbl_rem", rem, vecs[v].rem);
      check("tbl_short", shrt, vecs[v].shrt);
      check("tbl_empty", bus.stock_empty, vecs[v].empty);
      check("tbl_rem_held", bus.remaining, vecs[v].rem);
      if (vecs[v].lat != 0) check("tbl_latency", lat, vecs[v].lat);
    end

    // Start and restock in the same cycle: start wins, restock dropped
    do_reset();
    run_payout(5, 0, 1'b1, rem, shrt, lat);
    check("start_vs_restock_rem", rem, 5);
    check("start_vs_restock_short", shrt, 1);
    check("start_vs_restock_empty", bus.stock_empty, 4'b1111);

    // Hopper timeout, FAULT behaviour and maintenance clear
    do_reset();
    restock(1, 3);
    hop_en = 1'b0;
    bus.amount = AMT_W'(20); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 600 && !bus.fault; c++) begin
      if (bus.eject_req) cnt++;
      @(negedge clk);
    end
    check("tmo_req_cycles", cnt, TIMEOUT);
    check("tmo_fault", bus.fault, 1);
    check("tmo_busy", bus.busy, 0);
    check("tmo_req_low", bus.eject_req, 0);
    check("tmo_remaining", bus.remaining, 20);
    check("tmo_stock_kept", bus.stock_empty, 4'b1101);
    bus.amount = AMT_W'(5); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("fault_ignores_start", bus.fault, 1);
    check("fault_ignores_amount", bus.remaining, 20);
    restock(0, 1);
    check("fault_restock_keeps_fault", bus.fault, 1);
    check("fault_restock_empty", bus.stock_empty, 4'b1100);
    bus.maintenance = 1'b1;
    @(negedge clk);
    bus.maintenance = 1'b0;
    check("clear_fault", bus.fault, 0);
    check("clear_busy", bus.busy, 0);
    check("clear_remaining_kept", bus.remaining, 20);
    hop_en = 1'b1; hop_max = 0;
    pay_vs_model("after_fault", 70, 0);

    // Saturating restock: 250 + 10 caps at 255 coins of 50
    do_reset();
    restock(0, 250);
    restock(0, 10);
    for (int p = 0; p < 13; p++) pay_vs_model("sat", 1000, 0);
    check("sat_final_rem", bus.remaining, 250);
    check("sat_final_empty", bus.stock_empty, 4'b1111);

    // Start while busy is ignored
    do_reset();
    for (int s = 0; s < 4; s++) restock(s, 10);
    hop_max = 2;
    pay_vs_model("busy_start", 85, 3);

    // Randomized payouts against the model
    do_reset();
    hop_max = 3;
    for (int it = 0; it < 40; it++) begin
      int nrs;
      nrs = $urandom_range(0, 2);
      for (int r = 0; r < nrs; r++) restock($urandom_range(0, 3), $urandom_range(0, 6));
      pay_vs_model("rand", $urandom_range(0, 400), 0);
    end

    // Asynchronous reset while in REQ
    do_reset();
    restock(2, 1);
    hop_en = 1'b0;
    bus.amount = AMT_W'(10); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (!bus.eject_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("arst_reached_req", bus.eject_req, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_eject_req", bus.eject_req, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_remaining", bus.remaining, 0);
    check("arst_stock_empty", bus.stock_empty, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    hop_en = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
